// File: rtl/lif_array.sv
// ---------------------------------------------------------------------------
// lif_array
//   Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons that
//   share one update datapath. Each accepted request updates a single neuron
//   (selected by in_idx). The update leaks and integrates the membrane state,
//   compares it against an adaptive threshold, then applies a reset mode and a
//   refractory period. The result is registered and shown one cycle later.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   leak_sel     leak: 0 none, 1 s>>1, 2 s-(s>>2), 3 s-(s>>3)
//   in_valid     update request
//   in_ready     request accepted when in_valid & in_ready
//   in_idx       neuron to update (out-of-range: consumed, no update, no result)
//   in_current   unsigned input current
//   out_valid    result valid
//   out_ready    result consumed when out_valid & out_ready
//   out_idx      neuron index of result
//   out_spike    spike flag of this update
//   out_state    post-update membrane state
//   spike_count  total spikes since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module lif_array #(
    parameter int unsigned N_NEURONS   = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned THRESH0     = 230,
    parameter int unsigned ADAPT_INC   = 16,
    parameter int unsigned ADAPT_SHIFT = 3,
    parameter int unsigned REFRAC      = 2,
    parameter int unsigned RESET_MODE  = 0,
    localparam int unsigned IDX_W      = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       leak_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [WIDTH-1:0] in_current,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_spike,
    output logic [WIDTH-1:0] out_state,
    output logic [15:0]      spike_count
);

    localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    // Per-neuron storage
    logic [WIDTH-1:0] state_q  [N_NEURONS];
    logic [WIDTH-1:0] b_q      [N_NEURONS];
    logic [RW-1:0]    refrac_q [N_NEURONS];

    logic             accept;
    logic             idx_ok;
    logic [WIDTH-1:0] cur_s;
    logic [WIDTH-1:0] cur_b;
    logic [RW-1:0]    cur_r;
    logic [WIDTH-1:0] leaked;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] u;
    logic [WIDTH:0]   theta;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] bd;
    logic [WIDTH:0]   b_sum;
    logic [WIDTH-1:0] b_spk;
    logic             fire;
    logic             spike;
    logic [WIDTH-1:0] state_new;
    logic [WIDTH-1:0] b_new;
    logic [RW-1:0]    refrac_new;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Only non-power-of-two arrays can see an index beyond the last neuron.
    if ((2 ** IDX_W) > N_NEURONS) begin : g_idx_chk
        assign idx_ok = (32'(in_idx) < N_NEURONS);
    end else begin : g_idx_full
        assign idx_ok = 1'b1;
    end

    always_comb begin
        cur_s = state_q[in_idx];
        cur_b = b_q[in_idx];
        cur_r = refrac_q[in_idx];

        leaked = cur_s;
        case (leak_sel)
            2'd0:    leaked = cur_s;
            2'd1:    leaked = cur_s >> 1;
            2'd2:    leaked = cur_s - (cur_s >> 2);
            default: leaked = cur_s - (cur_s >> 3);
        endcase

        sum   = {1'b0, leaked} + {1'b0, in_current};
        u     = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        // One extra bit so THRESH0 + b never wraps.
        theta = (WIDTH + 1)'(THRESH0) + {1'b0, cur_b};
        fire  = ({1'b0, u} >= theta);
        diff  = {1'b0, u} - theta;

        bd    = cur_b - (cur_b >> ADAPT_SHIFT);
        b_sum = {1'b0, bd} + (WIDTH + 1)'(ADAPT_INC);
        b_spk = b_sum[WIDTH] ? '1 : b_sum[WIDTH-1:0];

        spike      = 1'b0;
        state_new  = u;
        b_new      = bd;
        refrac_new = '0;
        if (cur_r != '0) begin
            // Refractory: current ignored, membrane clamped, adaptation still decays.
            state_new  = '0;
            refrac_new = cur_r - 1'b1;
        end else if (fire) begin
            spike      = 1'b1;
            state_new  = (RESET_MODE != 0) ? diff[WIDTH-1:0] : '0;
            b_new      = b_spk;
            refrac_new = RW'(REFRAC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                state_q[i]  <= '0;
                b_q[i]      <= '0;
                refrac_q[i] <= '0;
            end
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_spike   <= 1'b0;
            out_state   <= '0;
            spike_count <= '0;
        end else if (accept) begin
            if (idx_ok) begin
                state_q[in_idx]  <= state_new;
                b_q[in_idx]      <= b_new;
                refrac_q[in_idx] <= refrac_new;
                out_valid        <= 1'b1;
                out_idx          <= in_idx;
                out_spike        <= spike;
                out_state        <= state_new;
                if (spike) begin
                    spike_count <= spike_count + 16'd1;
                end
            end else begin
                // Dropped request produces no result.
                out_valid <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lif_array.sv
// ---------------------------------------------------------------------------
// tb_lif_array
//   Drives two lif_array instances (reset mode 0 and reset mode 1) with the
//   same stimulus: directed steps followed by random traffic, and compares
//   both against an arithmetic reference model of the neuron rules.
// ---------------------------------------------------------------------------
module tb_lif_array;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  leak_sel;
    logic        in_valid;
    logic [1:0]  in_idx;
    logic [7:0]  in_current;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_spike0;
    logic [1:0]  out_idx0;
    logic [7:0]  out_state0;
    logic [15:0] spike_count0;
    logic        in_ready1, out_valid1, out_spike1;
    logic [1:0]  out_idx1;
    logic [7:0]  out_state1;
    logic [15:0] spike_count1;

    always #5 clk = ~clk;

    lif_array #(
        .N_NEURONS(4), .WIDTH(8), .THRESH0(230), .ADAPT_INC(16),
        .ADAPT_SHIFT(3), .REFRAC(2), .RESET_MODE(0)
    ) dut0 (
        .clk(clk), .rst(rst), .leak_sel(leak_sel), .in_valid(in_valid),
        .in_ready(in_ready0), .in_idx(in_idx), .in_current(in_current),
        .out_valid(out_valid0), .out_ready(out_ready), .out_idx(out_idx0),
        .out_spike(out_spike0), .out_state(out_state0), .spike_count(spike_count0)
    );

    lif_array #(
        .N_NEURONS(4), .WIDTH(8), .THRESH0(230), .ADAPT_INC(16),
        .ADAPT_SHIFT(3), .REFRAC(2), .RESET_MODE(1)
    ) dut1 (
        .clk(clk), .rst(rst), .leak_sel(leak_sel), .in_valid(in_valid),
        .in_ready(in_ready1), .in_idx(in_idx), .in_current(in_current),
        .out_valid(out_valid1), .out_ready(out_ready), .out_idx(out_idx1),
        .out_spike(out_spike1), .out_state(out_state1), .spike_count(spike_count1)
    );

    int tests = 0;
    int fails = 0;

    // Reference model, one copy per reset mode
    int m_state [2][4];
    int m_b     [2][4];
    int m_ref   [2][4];
    int m_cnt   [2];

    // Expected output registers
    bit e_valid;
    int e_idx;
    int e_spk [2];
    int e_st  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                m_state[m][i] = 0;
                m_b[m][i]     = 0;
                m_ref[m][i]   = 0;
            end
            m_cnt[m] = 0;
        end
        e_valid = 1'b0;
    endtask

    task automatic model_update(input int m, input int i, input int cur, input int leak,
                                output int sp, output int st);
        int s, l, u, theta, bd;
        s  = m_state[m][i];
        bd = m_b[m][i] - m_b[m][i] / 8;
        sp = 0;
        if (m_ref[m][i] != 0) begin
            m_ref[m][i]   = m_ref[m][i] - 1;
            m_state[m][i] = 0;
            m_b[m][i]     = bd;
        end else begin
            case (leak)
                0:       l = s;
                1:       l = s / 2;
                2:       l = s - s / 4;
                default: l = s - s / 8;
            endcase
            u     = (l + cur > 255) ? 255 : l + cur;
            theta = 230 + m_b[m][i];
            if (u >= theta) begin
                sp            = 1;
                m_state[m][i] = (m == 1) ? u - theta : 0;
                m_b[m][i]     = (bd + 16 > 255) ? 255 : bd + 16;
                m_ref[m][i]   = 2;
                m_cnt[m]      = (m_cnt[m] + 1) % 65536;
            end else begin
                m_state[m][i] = u;
                m_b[m][i]     = bd;
            end
        end
        st = m_state[m][i];
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_valid0", 32'(out_valid0), 0);
        chk("rst_valid1", 32'(out_valid1), 0);
        chk("rst_count0", 32'(spike_count0), 0);
        chk("rst_count1", 32'(spike_count1), 0);
        chk("rst_ready0", 32'(in_ready0), 1);
        chk("rst_state0", 32'(out_state0), 0);
        chk("rst_idx0", 32'(out_idx0), 0);
        chk("rst_spike1", 32'(out_spike1), 0);
        rst = 1'b0;
    endtask

    // One clock cycle of stimulus followed by checks of both instances.
    task automatic step(input bit v, input int idx, input int cur, input int leak,
                        input bit ordy);
        bit rdy;
        int sp, st;
        in_valid   = v;
        in_idx     = idx[1:0];
        in_current = cur[7:0];
        leak_sel   = leak[1:0];
        out_ready  = ordy;
        #1;
        rdy = !e_valid || ordy;
        chk("in_ready0", 32'(in_ready0), 32'(rdy));
        chk("in_ready1", 32'(in_ready1), 32'(rdy));
        @(posedge clk);
        #1;
        if (v && rdy) begin
            for (int m = 0; m < 2; m++) begin
                model_update(m, idx, cur, leak, sp, st);
                e_spk[m] = sp;
                e_st[m]  = st;
            end
            e_valid = 1'b1;
            e_idx   = idx;
        end else if (ordy) begin
            e_valid = 1'b0;
        end
        chk("out_valid0", 32'(out_valid0), 32'(e_valid));
        chk("out_valid1", 32'(out_valid1), 32'(e_valid));
        if (e_valid) begin
            chk("out_idx0", 32'(out_idx0), e_idx);
            chk("out_idx1", 32'(out_idx1), e_idx);
            chk("out_spike0", 32'(out_spike0), e_spk[0]);
            chk("out_spike1", 32'(out_spike1), e_spk[1]);
            chk("out_state0", 32'(out_state0), e_st[0]);
            chk("out_state1", 32'(out_state1), e_st[1]);
        end
        chk("spike_count0", 32'(spike_count0), m_cnt[0]);
        chk("spike_count1", 32'(spike_count1), m_cnt[1]);
    endtask

    initial begin
        int t2 [9];
        int t3 [5];
        int cur;

        t2 = '{100, 150, 175, 187, 193, 196, 198, 199, 199};
        t3 = '{120, 0, 0, 0, 120};
        leak_sel   = 2'd0;
        in_idx     = 2'd0;
        in_current = 8'd0;

        // Reset state
        do_reset();

        // Halving leak converges below threshold
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 0, 100, 1, 1'b1);
            chk("t2_state", 32'(out_state0), t2[k]);
        end
        chk("t2_count", 32'(spike_count0), 0);

        // Spike, refractory, adapted threshold
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1, 120, 0, 1'b1);
            chk("t3_state", 32'(out_state0), t3[k]);
        end
        chk("t3_count", 32'(spike_count0), 1);

        // Interleaved neurons with saturating current
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, (k % 2 == 1) ? 2 : 0, 255, 0, 1'b1);
        end
        chk("t4_count", 32'(spike_count0), 2);

        // Back-pressure: held outputs, nothing lost
        step(1'b1, 1, 50, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2, 60, 0, 1'b0);
            chk("t5_hold", 32'(out_state0), 50);
        end
        step(1'b1, 2, 60, 0, 1'b1);
        step(1'b1, 3, 70, 2, 1'b1);

        // Subtractive reset on the mode-1 instance
        do_reset();
        step(1'b1, 3, 200, 0, 1'b1);
        step(1'b1, 3, 100, 0, 1'b1);
        chk("t6_state1", 32'(out_state1), 25);
        chk("t6_spike1", 32'(out_spike1), 1);
        chk("t6_state0", 32'(out_state0), 0);

        // Random traffic, with one reset in the middle
        for (int k = 0; k < 500; k++) begin
            if (k == 250) do_reset();
            case ($urandom_range(0, 3))
                0:       cur = 255;
                1:       cur = $urandom_range(150, 255);
                default: cur = $urandom_range(0, 255);
            endcase
            step(($urandom_range(0, 9) < 8), $urandom_range(0, 3), cur,
                 $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
        end
        step(1'b0, 0, 0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
